// File: rtl/multicycle_adder.sv
// rtl/multicycle_adder.sv - sliced add/subtract, one SLICE-bit slice per clock, LSB first.
// Operands are shifted right as slices are consumed; the partial sum fills from the top.
module multicycle_adder #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic             c_in,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [SLICE-1:0]       slice_s;
  logic                   slice_c;
  logic                   msb_cin;
  logic [WIDTH+SLICE-1:0] part_cat;
  logic [WIDTH-1:0]       part_next;

  // Only the low slice of each shifted operand feeds the short carry chain.
  assign {slice_c, slice_s} = {1'b0, a_q[SLICE-1:0]} + {1'b0, b_q[SLICE-1:0]}
                            + {{SLICE{1'b0}}, carry_q};
  assign msb_cin   = a_q[SLICE-1] ^ b_q[SLICE-1] ^ slice_s[SLICE-1];
  assign part_cat  = {slice_s, part_q};
  assign part_next = part_cat[WIDTH+SLICE-1:SLICE];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      part_q  <= part_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    part_d  = part_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = in_1;
          b_d     = sub ? ~in_2 : in_2;
          carry_d = sub ? 1'b1 : c_in;
          part_d  = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> SLICE;
        b_d     = b_q >> SLICE;
        part_d  = part_next;
        carry_d = slice_c;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          sum_d   = part_next;
          c_out_d = slice_c;
          ovf_d   = msb_cin ^ slice_c;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy  = (state_q == RUN);
  assign done  = done_q;
  assign sum   = sum_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_multicycle_adder.sv
// tb/tb_multicycle_adder.sv - directed vectors for multicycle_adder at 32/8, 8/8 and 16/4.
module tb_multicycle_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start32, cin32, sub32, busy32, done32, c32, o32;
  logic [31:0] in1_32, in2_32, sum32;
  logic        start8, cin8, sub8, busy8, done8, c8, o8;
  logic [7:0]  in1_8, in2_8, sum8;
  logic        start16, cin16, sub16, busy16, done16, c16, o16;
  logic [15:0] in1_16, in2_16, sum16;

  int vectors = 0;
  int miscompares = 0;

  multicycle_adder #(.WIDTH(32), .SLICE(8)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .in_1(in1_32), .in_2(in2_32),
    .c_in(cin32), .sub(sub32), .busy(busy32), .done(done32), .sum(sum32),
    .c_out(c32), .ovf(o32));

  multicycle_adder #(.WIDTH(8), .SLICE(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .in_1(in1_8), .in_2(in2_8),
    .c_in(cin8), .sub(sub8), .busy(busy8), .done(done8), .sum(sum8),
    .c_out(c8), .ovf(o8));

  multicycle_adder #(.WIDTH(16), .SLICE(4)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .in_1(in1_16), .in_2(in2_16),
    .c_in(cin16), .sub(sub16), .busy(busy16), .done(done16), .sum(sum16),
    .c_out(c16), .ovf(o16));

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Returns edges until done32 is seen, 0 if it never appears within the budget.
  task automatic wait_done32(output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done32) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run32(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic s, input logic [31:0] exp_sum,
                       input logic exp_c, input logic exp_o);
    int lat;
    in1_32 = a; in2_32 = b; cin32 = cin; sub32 = s; start32 = 1'b1;
    tick();
    start32 = 1'b0;
    in1_32 = ~a; in2_32 = ~b; cin32 = ~cin; sub32 = ~s;
    expect_eq({tag, "_busy"}, {31'd0, busy32}, 32'd1);
    wait_done32(lat);
    expect_eq({tag, "_lat"}, lat, 32'd4);
    expect_eq({tag, "_sum"}, sum32, exp_sum);
    expect_eq({tag, "_cout"}, {31'd0, c32}, {31'd0, exp_c});
    expect_eq({tag, "_ovf"}, {31'd0, o32}, {31'd0, exp_o});
    expect_eq({tag, "_idle"}, {31'd0, busy32}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int dones;
    rst = 1'b1;
    start32 = 0; cin32 = 0; sub32 = 0; in1_32 = '0; in2_32 = '0;
    start8 = 0; cin8 = 0; sub8 = 0; in1_8 = '0; in2_8 = '0;
    start16 = 0; cin16 = 0; sub16 = 0; in1_16 = '0; in2_16 = '0;
    tick();
    tick();
    rst = 1'b0;
    expect_eq("rst_busy", {31'd0, busy32}, 32'd0);
    expect_eq("rst_done", {31'd0, done32}, 32'd0);
    expect_eq("rst_sum", sum32, 32'd0);
    expect_eq("rst_cout", {31'd0, c32}, 32'd0);
    expect_eq("rst_ovf", {31'd0, o32}, 32'd0);

    // Wrap to zero, then check the done pulse lasts one cycle and sum holds.
    run32("ffff_p1", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    tick();
    expect_eq("pulse_clr", {31'd0, done32}, 32'd0);
    expect_eq("sum_hold", sum32, 32'h0000_0000);

    run32("pos_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run32("cin_prop", 32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    run32("sub_neg", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run32("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

    // Start during busy is ignored; start in the done cycle is accepted.
    in1_32 = 32'd1; in2_32 = 32'd2; cin32 = 0; sub32 = 0; start32 = 1'b1;
    tick();
    start32 = 1'b0;
    tick();
    in1_32 = 32'h100; in2_32 = 32'h100; start32 = 1'b1;
    tick();
    start32 = 1'b0;
    wait_done32(lat);
    expect_eq("ign_lat", lat, 32'd2);
    expect_eq("ign_sum", sum32, 32'd3);
    in1_32 = 32'h10; in2_32 = 32'h10; start32 = 1'b1;
    tick();
    start32 = 1'b0;
    expect_eq("b2b_busy", {31'd0, busy32}, 32'd1);
    wait_done32(lat);
    expect_eq("b2b_lat", lat, 32'd4);
    expect_eq("b2b_sum", sum32, 32'h20);

    // Reset on the second RUN edge aborts with no done pulse.
    in1_32 = 32'hAB00_AB00; in2_32 = 32'hAA00_AA00; start32 = 1'b1;
    tick();
    start32 = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_eq("abort_busy", {31'd0, busy32}, 32'd0);
    expect_eq("abort_done", {31'd0, done32}, 32'd0);
    expect_eq("abort_sum", sum32, 32'd0);
    expect_eq("abort_cout", {31'd0, c32}, 32'd0);
    expect_eq("abort_ovf", {31'd0, o32}, 32'd0);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      dones += int'(done32);
    end
    expect_eq("abort_nodone", dones, 32'd0);
    run32("post_rst", 32'h0000_008A, 32'h0000_0082, 1'b0, 1'b0, 32'h0000_010C, 1'b0, 1'b0);

    // Single-slice instance: done one edge after acceptance.
    in1_8 = 8'hFF; in2_8 = 8'hFF; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    in1_8 = 8'h00; in2_8 = 8'h00;
    expect_eq("w8_busy", {31'd0, busy8}, 32'd1);
    tick();
    expect_eq("w8_done", {31'd0, done8}, 32'd1);
    expect_eq("w8_sum", {24'd0, sum8}, 32'h0000_00FE);
    expect_eq("w8_cout", {31'd0, c8}, 32'd1);
    expect_eq("w8_ovf", {31'd0, o8}, 32'd0);

    // 16/4: mixed-sign operands cannot overflow.
    in1_16 = 16'hBE82; in2_16 = 16'h0B00; start16 = 1'b1;
    tick();
    start16 = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done16) begin
        lat = i;
        break;
      end
    end
    expect_eq("w16_lat", lat, 32'd4);
    expect_eq("w16_sum", {16'd0, sum16}, 32'h0000_C982);
    expect_eq("w16_cout", {31'd0, c16}, 32'd0);
    expect_eq("w16_ovf", {31'd0, o16}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
